// File: rtl/uart_fifo.sv
// 8N1 UART with independent RX/TX byte FIFOs, compile-time baud divider,
// fill-level counts and sticky overrun / framing error flags.

module uart_fifo_q #(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pop,
  output logic [7:0]    dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end
endmodule

module uart_fifo #(
  parameter  int CLK_DIV = 104,
  parameter  int DEPTH   = 16,
  localparam int CW      = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rx,
  output logic          tx,
  input  logic          wr,
  input  logic [7:0]    tx_data,
  input  logic          rd,
  output logic [7:0]    rx_data,
  output logic          valid,
  output logic          busy,
  output logic          tx_idle,
  output logic [CW-1:0] rx_count,
  output logic [CW-1:0] tx_count,
  output logic          overrun,
  output logic          frame_err,
  input  logic          clr_err
);
  localparam logic [15:0] DIV_M1  = 16'(CLK_DIV - 1);
  localparam logic [15:0] HALF_M1 = 16'(CLK_DIV / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;

  // Reset asserts asynchronously but releases on a clock edge.
  logic [1:0] rst_q;
  logic       rst;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rst_q <= 2'b11;
    else       rst_q <= {rst_q[0], 1'b0};
  end
  assign rst = rst_q[1];

  // ---------------- TX path ----------------
  logic       tx_pop, tx_full, tx_empty;
  logic [7:0] tx_dout;

  uart_fifo_q #(.DEPTH(DEPTH), .CW(CW)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(wr), .din(tx_data), .pop(tx_pop),
    .dout(tx_dout), .count(tx_count), .full(tx_full), .empty(tx_empty)
  );

  tx_state_t   tx_state, tx_state_nx;
  logic [15:0] tx_cnt, tx_cnt_nx;
  logic [2:0]  tx_bit, tx_bit_nx;
  logic [7:0]  tx_sr, tx_sr_nx;
  logic        tx_nx;

  always_comb begin
    tx_state_nx = tx_state;
    tx_cnt_nx   = tx_cnt;
    tx_bit_nx   = tx_bit;
    tx_sr_nx    = tx_sr;
    tx_nx       = tx;
    tx_pop      = 1'b0;
    unique case (tx_state)
      TX_IDLE: begin
        tx_nx = 1'b1;
        if (!tx_empty) begin
          tx_pop      = 1'b1;
          tx_sr_nx    = tx_dout;
          tx_cnt_nx   = DIV_M1;
          tx_nx       = 1'b0;
          tx_state_nx = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt == '0) begin
          tx_cnt_nx   = DIV_M1;
          tx_bit_nx   = '0;
          tx_nx       = tx_sr[0];
          tx_state_nx = TX_DATA;
        end else begin
          tx_cnt_nx = tx_cnt - 1'b1;
        end
      end
      TX_DATA: begin
        if (tx_cnt == '0) begin
          tx_cnt_nx = DIV_M1;
          if (tx_bit == 3'd7) begin
            tx_nx       = 1'b1;
            tx_state_nx = TX_STOP;
          end else begin
            tx_sr_nx  = tx_sr >> 1;
            tx_nx     = tx_sr[1];
            tx_bit_nx = tx_bit + 1'b1;
          end
        end else begin
          tx_cnt_nx = tx_cnt - 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_cnt == '0) begin
          // Chain straight into the next start bit so bursts leave no idle gap.
          if (!tx_empty) begin
            tx_pop      = 1'b1;
            tx_sr_nx    = tx_dout;
            tx_cnt_nx   = DIV_M1;
            tx_nx       = 1'b0;
            tx_state_nx = TX_START;
          end else begin
            tx_state_nx = TX_IDLE;
          end
        end else begin
          tx_cnt_nx = tx_cnt - 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx       <= 1'b1;
    end else begin
      tx_state <= tx_state_nx;
      tx_cnt   <= tx_cnt_nx;
      tx_bit   <= tx_bit_nx;
      tx       <= tx_nx;
    end
  end

  always_ff @(posedge clk) tx_sr <= tx_sr_nx;

  assign busy    = tx_full;
  assign tx_idle = (tx_state == TX_IDLE) && tx_empty;

  // ---------------- RX path ----------------
  logic rx_p0, rx_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_p1 <= rx_p0;
    end
  end

  rx_state_t   rx_state, rx_state_nx;
  logic [15:0] rx_cnt, rx_cnt_nx;
  logic [2:0]  rx_bit, rx_bit_nx;
  logic [7:0]  rx_sr, rx_sr_nx;
  logic        rx_push, frame_set, overrun_set;
  logic        rx_full, rx_empty;
  logic [7:0]  rx_dout;

  always_comb begin
    rx_state_nx = rx_state;
    rx_cnt_nx   = rx_cnt;
    rx_bit_nx   = rx_bit;
    rx_sr_nx    = rx_sr;
    rx_push     = 1'b0;
    frame_set   = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (!rx_p1) begin
          rx_cnt_nx   = HALF_M1;
          rx_state_nx = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt == '0) begin
          if (rx_p1) begin
            rx_state_nx = RX_IDLE;
          end else begin
            rx_cnt_nx   = DIV_M1;
            rx_bit_nx   = '0;
            rx_state_nx = RX_DATA;
          end
        end else begin
          rx_cnt_nx = rx_cnt - 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt == '0) begin
          rx_sr_nx  = {rx_p1, rx_sr[7:1]};
          rx_cnt_nx = DIV_M1;
          if (rx_bit == 3'd7) rx_state_nx = RX_STOP;
          else                rx_bit_nx   = rx_bit + 1'b1;
        end else begin
          rx_cnt_nx = rx_cnt - 1'b1;
        end
      end
      RX_STOP: begin
        // Leave at mid stop bit so the next start edge is caught early.
        if (rx_cnt == '0) begin
          if (rx_p1) begin
            rx_push     = 1'b1;
            rx_state_nx = RX_IDLE;
          end else begin
            frame_set   = 1'b1;
            rx_state_nx = RX_BREAK;
          end
        end else begin
          rx_cnt_nx = rx_cnt - 1'b1;
        end
      end
      RX_BREAK: begin
        if (rx_p1) rx_state_nx = RX_IDLE;
      end
      default: rx_state_nx = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
    end else begin
      rx_state <= rx_state_nx;
      rx_cnt   <= rx_cnt_nx;
      rx_bit   <= rx_bit_nx;
    end
  end

  always_ff @(posedge clk) rx_sr <= rx_sr_nx;

  uart_fifo_q #(.DEPTH(DEPTH), .CW(CW)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .din(rx_sr), .pop(rd),
    .dout(rx_dout), .count(rx_count), .full(rx_full), .empty(rx_empty)
  );

  assign overrun_set = rx_push && rx_full && !rd;
  assign valid       = !rx_empty;
  assign rx_data     = valid ? rx_dout : 8'h00;

  // Sticky flags: a same-cycle set beats clr_err.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (overrun_set)  overrun <= 1'b1;
      else if (clr_err) overrun <= 1'b0;
      if (frame_set)    frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_fifo.sv
// Randomised bench for uart_fifo: line-level TX decoder and queue-based RX model.

module tb_uart_fifo;
  localparam int CLK_DIV = 8;
  localparam int DEPTH   = 16;
  localparam int CW      = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset, rx, tx, wr, rd, valid, busy, tx_idle, overrun, frame_err, clr_err;
  logic [7:0]    tx_data, rx_data;
  logic [CW-1:0] rx_count, tx_count;

  int total = 0;
  int bad   = 0;

  logic [7:0] mon_b [$];
  logic       mon_s [$];
  time        mon_t [$];

  always #5 clk = ~clk;

  uart_fifo #(.CLK_DIV(CLK_DIV), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .rx(rx), .tx(tx), .wr(wr), .tx_data(tx_data),
    .rd(rd), .rx_data(rx_data), .valid(valid), .busy(busy), .tx_idle(tx_idle),
    .rx_count(rx_count), .tx_count(tx_count), .overrun(overrun),
    .frame_err(frame_err), .clr_err(clr_err)
  );

  // Line decoder: samples each bit at its middle and logs byte, stop bit, start time.
  initial begin
    logic [7:0] b;
    time        t0;
    forever begin
      @(negedge tx);
      t0 = $time;
      repeat (CLK_DIV / 2) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (CLK_DIV) @(posedge clk);
        b[i] = tx;
      end
      repeat (CLK_DIV) @(posedge clk);
      mon_b.push_back(b);
      mon_s.push_back(tx);
      mon_t.push_back(t0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      if (tx_idle) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic send_serial(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CLK_DIV) tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CLK_DIV) tick();
    end
    rx = stop;
    repeat (CLK_DIV) tick();
  endtask

  task automatic test_reset();
    logic [CW*2+14:0] got;
    logic [CW*2+14:0] exp;
    reset = 1'b1; rx = 1'b1; wr = 1'b0; rd = 1'b0; clr_err = 1'b0; tx_data = 8'h00;
    repeat (3) tick();
    for (int k = 0; k < 2; k++) begin
      got = {tx, valid, busy, tx_idle, rx_count, tx_count, overrun, frame_err, rx_data};
      exp = {1'b1, 1'b0, 1'b0, 1'b1, CW'(0), CW'(0), 1'b0, 1'b0, 8'h00};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL reset_state%0d: got %h expected %h", k, got, exp);
      end
      if (k == 0) begin
        reset = 1'b0;
        repeat (5) tick();
      end
    end
  endtask

  task automatic test_tx_single();
    logic [7:0] b = 8'h55;
    logic       exp_bit;
    int         errs;
    wr = 1'b1; tx_data = b;
    tick();
    wr = 1'b0;
    total++;
    if (tx !== 1'b1 || tx_count !== CW'(1)) begin
      bad++;
      $display("FAIL tx_first_edge: got tx=%b cnt=%0d expected tx=1 cnt=1", tx, tx_count);
    end
    tick();
    for (int bitn = 0; bitn < 10; bitn++) begin
      exp_bit = (bitn == 0) ? 1'b0 : (bitn == 9) ? 1'b1 : b[bitn-1];
      errs = 0;
      for (int c = 0; c < CLK_DIV; c++) begin
        if (tx !== exp_bit || tx_idle !== 1'b0) errs++;
        tick();
      end
      total++;
      if (errs != 0) begin
        bad++;
        $display("FAIL tx_bit%0d: got %0d bad cycles expected level %b busy-line", bitn, errs, exp_bit);
      end
    end
    total++;
    if (tx_idle !== 1'b1 || tx !== 1'b1) begin
      bad++;
      $display("FAIL tx_idle_after_frame: got idle=%b tx=%b expected 1 1", tx_idle, tx);
    end
  endtask

  task automatic test_tx_burst();
    logic [7:0] bytes [DEPTH+2];
    int         exp_cnt;
    bit         ok;
    mon_b.delete(); mon_s.delete(); mon_t.delete();
    for (int k = 0; k < DEPTH + 2; k++) bytes[k] = 8'($urandom);
    for (int k = 0; k < DEPTH + 2; k++) begin
      wr = 1'b1; tx_data = bytes[k];
      tick();
      exp_cnt = (k == 0) ? 1 : ((k < DEPTH) ? k : DEPTH);
      total++;
      if (tx_count !== CW'(exp_cnt) || busy !== (exp_cnt == DEPTH)) begin
        bad++;
        $display("FAIL burst_count%0d: got cnt=%0d busy=%b expected cnt=%0d busy=%b",
                 k, tx_count, busy, exp_cnt, exp_cnt == DEPTH);
      end
    end
    wr = 1'b0;
    wait_idle((DEPTH + 2) * 10 * CLK_DIV + 50, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL burst_drain: got tx_idle=0 expected 1");
    end
    repeat (4) tick();
    total++;
    if (mon_b.size() != DEPTH + 1) begin
      bad++;
      $display("FAIL burst_frames: got %0d expected %0d", mon_b.size(), DEPTH + 1);
    end else begin
      for (int k = 0; k < DEPTH + 1; k++) begin
        total++;
        if (mon_b[k] !== bytes[k] || mon_s[k] !== 1'b1) begin
          bad++;
          $display("FAIL burst_byte%0d: got %h stop=%b expected %h stop=1", k, mon_b[k], mon_s[k], bytes[k]);
        end
        if (k > 0) begin
          total++;
          if (mon_t[k] - mon_t[k-1] != 10 * CLK_DIV * 10) begin
            bad++;
            $display("FAIL burst_gap%0d: got %0t expected %0d", k, mon_t[k] - mon_t[k-1], 10 * CLK_DIV * 10);
          end
        end
      end
    end
  endtask

  task automatic test_rx_single();
    int lat = -1;
    rd = 1'b1;
    tick();
    rd = 1'b0;
    total++;
    if (rx_count !== CW'(0) || valid !== 1'b0) begin
      bad++;
      $display("FAIL rd_empty: got cnt=%0d valid=%b expected 0 0", rx_count, valid);
    end
    fork
      send_serial(8'hA3, 1'b1);
      begin
        for (int i = 1; i <= 120; i++) begin
          tick();
          if (valid === 1'b1 && lat < 0) lat = i;
        end
      end
    join
    total++;
    if (lat < 74 || lat > 84) begin
      bad++;
      $display("FAIL rx_latency: got %0d expected about %0d", lat, 78);
    end
    total++;
    if (rx_data !== 8'hA3 || rx_count !== CW'(1) || valid !== 1'b1) begin
      bad++;
      $display("FAIL rx_byte: got %h cnt=%0d valid=%b expected a3 1 1", rx_data, rx_count, valid);
    end
    rd = 1'b1;
    tick();
    rd = 1'b0;
    total++;
    if (valid !== 1'b0 || rx_data !== 8'h00 || rx_count !== CW'(0)) begin
      bad++;
      $display("FAIL rx_pop: got valid=%b data=%h cnt=%0d expected 0 00 0", valid, rx_data, rx_count);
    end
  endtask

  task automatic test_rx_overrun();
    logic [7:0] model [$];
    logic [7:0] b;
    logic       ovr_exp = 1'b0;
    for (int k = 0; k < DEPTH + 1; k++) begin
      b = 8'($urandom);
      if (model.size() < DEPTH) model.push_back(b);
      else                      ovr_exp = 1'b1;
      send_serial(b, 1'b1);
      if (k >= DEPTH - 1) begin
        total++;
        if (overrun !== ovr_exp || rx_count !== CW'(model.size())) begin
          bad++;
          $display("FAIL ovr_after%0d: got ovr=%b cnt=%0d expected %b %0d", k, overrun, rx_count, ovr_exp, model.size());
        end
      end
    end
    tick();
    for (int k = 0; k < DEPTH; k++) begin
      total++;
      if (valid !== 1'b1 || rx_data !== model[k]) begin
        bad++;
        $display("FAIL ovr_order%0d: got %h expected %h", k, rx_data, model[k]);
      end
      rd = 1'b1;
      tick();
      rd = 1'b0;
    end
    total++;
    if (valid !== 1'b0 || overrun !== 1'b1) begin
      bad++;
      $display("FAIL ovr_drained: got valid=%b ovr=%b expected 0 1", valid, overrun);
    end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    total++;
    if (overrun !== 1'b0) begin
      bad++;
      $display("FAIL ovr_clear: got %b expected 0", overrun);
    end
  endtask

  task automatic test_rx_errors();
    logic [7:0] b = 8'($urandom);
    send_serial(b, 1'b0);
    rx = 1'b1;
    repeat (10) tick();
    total++;
    if (frame_err !== 1'b1 || rx_count !== CW'(0) || overrun !== 1'b0) begin
      bad++;
      $display("FAIL frame_err: got fe=%b cnt=%0d ovr=%b expected 1 0 0", frame_err, rx_count, overrun);
    end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    total++;
    if (frame_err !== 1'b0) begin
      bad++;
      $display("FAIL frame_clear: got %b expected 0", frame_err);
    end
    rx = 1'b0;
    repeat (3) tick();
    rx = 1'b1;
    repeat (100) tick();
    total++;
    if (rx_count !== CW'(0) || frame_err !== 1'b0 || overrun !== 1'b0) begin
      bad++;
      $display("FAIL glitch: got cnt=%0d fe=%b ovr=%b expected 0 0 0", rx_count, frame_err, overrun);
    end
    b = 8'($urandom);
    send_serial(b, 1'b1);
    tick();
    total++;
    if (rx_data !== b || rx_count !== CW'(1)) begin
      bad++;
      $display("FAIL rx_after_glitch: got %h cnt=%0d expected %h 1", rx_data, rx_count, b);
    end
    rd = 1'b1;
    tick();
    rd = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    bit         ok;
    for (int k = 0; k < 3; k++) begin
      wr = 1'b1; tx_data = 8'($urandom);
      tick();
    end
    wr = 1'b0;
    total++;
    if (tx !== 1'b0 || tx_count !== CW'(2)) begin
      bad++;
      $display("FAIL pre_reset: got tx=%b cnt=%0d expected 0 2", tx, tx_count);
    end
    tick();
    reset = 1'b1;
    #1;
    total++;
    if (tx !== 1'b1 || tx_count !== CW'(0) || busy !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: got tx=%b cnt=%0d busy=%b expected 1 0 0", tx, tx_count, busy);
    end
    repeat (3) tick();
    reset = 1'b0;
    repeat (6) tick();
    total++;
    if (tx_idle !== 1'b1 || tx !== 1'b1) begin
      bad++;
      $display("FAIL post_reset: got idle=%b tx=%b expected 1 1", tx_idle, tx);
    end
    repeat (100) tick();
    mon_b.delete(); mon_s.delete(); mon_t.delete();
    b = 8'($urandom);
    wr = 1'b1; tx_data = b;
    tick();
    wr = 1'b0;
    wait_idle(10 * CLK_DIV + 20, ok);
    repeat (4) tick();
    total++;
    if (!ok || mon_b.size() != 1) begin
      bad++;
      $display("FAIL clean_frame: got idle=%b frames=%0d expected 1 1", ok, mon_b.size());
    end else begin
      total++;
      if (mon_b[0] !== b || mon_s[0] !== 1'b1) begin
        bad++;
        $display("FAIL clean_byte: got %h stop=%b expected %h 1", mon_b[0], mon_s[0], b);
      end
    end
  endtask

  initial begin
    test_reset();
    test_tx_single();
    test_tx_burst();
    test_rx_single();
    test_rx_overrun();
    test_rx_errors();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
